// File: rtl/rv_pkg.sv
// Shared RV32I encoding definitions: instruction formats, base opcodes and field widths.
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int OPC_W = 7;
  localparam int REG_W = 5;
  localparam int F3_W  = 3;
  localparam int F7_W  = 7;
  localparam int FMT_W = 3;

  typedef enum logic [FMT_W-1:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [OPC_W-1:0] OP_OP     = 7'h33;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'h13;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'h23;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'h63;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'h37;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'h6F;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: places decoded fields into a 32-bit word per format.
module instr_pack
  import rv_pkg::*;
(
  input  logic [FMT_W-1:0] fmt,
  input  logic [OPC_W-1:0] opcode,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [F3_W-1:0]  funct3,
  input  logic [F7_W-1:0]  funct7,
  input  logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  instr,
  output logic             illegal,
  output logic             misalign
);

  // Format-specific bit placement; B/J drop imm[0] and report it as misaligned.
  always_comb begin
    instr    = 32'h0000_0000;
    illegal  = 1'b0;
    misalign = 1'b0;
    case (fmt)
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: begin
        instr    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        misalign = imm[0];
      end
      FMT_U: instr = {imm[31:12], rd, opcode};
      FMT_J: begin
        instr    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        misalign = imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with program-load sequencing: packs field bundles into
// instruction words and emits them with sequential word addresses over one load run.
module instr_encoder
  import rv_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FMT_W-1:0]  in_fmt,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic [F3_W-1:0]   in_funct3,
  input  logic [F7_W-1:0]   in_funct7,
  input  logic [XLEN-1:0]   in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_misalign
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ADDR_W:0]   accepted_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W-1:0] addr_nxt_r;
  logic [ADDR_W-1:0] out_addr_r;
  logic [XLEN-1:0]   out_instr_r;
  logic              out_valid_r;
  logic              err_ill_r;
  logic              err_mis_r;

  logic [XLEN-1:0]   word_s;
  logic              illegal_s;
  logic              misalign_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              emit_s;
  logic              drain_s;
  logic              restart_s;
  logic              run_end_s;

  instr_pack u_pack (
    .fmt      (in_fmt),
    .opcode   (in_opcode),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .funct3   (in_funct3),
    .funct7   (in_funct7),
    .imm      (in_imm),
    .instr    (word_s),
    .illegal  (illegal_s),
    .misalign (misalign_s)
  );

  assign in_ready_s = (state_r == ST_RUN) && (accepted_r < DEPTH_C) && (!out_valid_r || out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign emit_s     = accept_s && !illegal_s;
  assign drain_s    = out_valid_r && out_ready;
  assign restart_s  = start && (state_r != ST_RUN);
  // The run ends only after every bundle is taken and the output register is empty.
  assign run_end_s  = (state_r == ST_RUN) && (accepted_r == DEPTH_C) && (!out_valid_r || drain_s);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = state_r;
      end
      ST_RUN: begin
        if (run_end_s) state_nxt_s = ST_DONE;
        else           state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output register, address/count tracking and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accepted_r  <= '0;
      count_r     <= '0;
      addr_nxt_r  <= BASE_C;
      out_addr_r  <= BASE_C;
      out_instr_r <= 32'h0000_0000;
      out_valid_r <= 1'b0;
      err_ill_r   <= 1'b0;
      err_mis_r   <= 1'b0;
    end else if (restart_s) begin
      accepted_r  <= '0;
      count_r     <= '0;
      addr_nxt_r  <= BASE_C;
      out_valid_r <= 1'b0;
      err_ill_r   <= 1'b0;
      err_mis_r   <= 1'b0;
    end else begin
      if (accept_s) accepted_r <= accepted_r + CNT_ONE;
      if (accept_s && illegal_s) err_ill_r <= 1'b1;
      if (emit_s && misalign_s) err_mis_r <= 1'b1;
      if (emit_s) begin
        out_valid_r <= 1'b1;
        out_instr_r <= word_s;
        out_addr_r  <= addr_nxt_r;
        addr_nxt_r  <= addr_nxt_r + ADDR_ONE;
      end else if (drain_s) begin
        out_valid_r <= 1'b0;
      end
      if (drain_s) count_r <= count_r + CNT_ONE;
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = out_valid_r;
  assign out_instr    = out_instr_r;
  assign out_addr     = out_addr_r;
  assign count        = count_r;
  assign busy         = (state_r == ST_RUN);
  assign done         = (state_r == ST_DONE);
  assign err_illegal  = err_ill_r;
  assign err_misalign = err_mis_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings plus randomized runs
// compared every cycle against a queue-based reference model.
module tb_instr_encoder;

  localparam int ADDR_W    = 10;
  localparam int DEPTH     = 8;
  localparam int BASE_ADDR = 1020;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic [2:0]        in_fmt = 3'd0;
  logic [6:0]        in_opcode = 7'd0;
  logic [4:0]        in_rd = 5'd0;
  logic [4:0]        in_rs1 = 5'd0;
  logic [4:0]        in_rs2 = 5'd0;
  logic [2:0]        in_funct3 = 3'd0;
  logic [6:0]        in_funct7 = 7'd0;
  logic [31:0]       in_imm = 32'd0;
  logic              in_ready;
  logic              out_valid;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              err_illegal;
  logic              err_misalign;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .count(count), .busy(busy), .done(done),
    .err_illegal(err_illegal), .err_misalign(err_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference encoder: each field shifted to its documented bit position.
  function automatic int unsigned ref_word(input int unsigned fmt, input int unsigned op,
                                           input int unsigned rd, input int unsigned rs1,
                                           input int unsigned rs2, input int unsigned f3,
                                           input int unsigned f7, input int unsigned imm);
    int unsigned w;
    case (fmt)
      0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      1: w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      2: w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
             | ((imm & 32'h1F) << 7) | op;
      3: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
             | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
             | (((imm >> 11) & 32'h1) << 7) | op;
      4: w = (imm & 32'hFFFFF000) | (rd << 7) | op;
      5: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
             | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
      default: w = 0;
    endcase
    return w;
  endfunction

  // Reference model: 0 idle, 1 run, 2 done; the queue holds words awaiting handshake.
  int          m_state = 0;
  int          m_acc   = 0;
  int unsigned m_cnt   = 0;
  int unsigned m_addr  = BASE_ADDR;
  bit          m_ill   = 1'b0;
  bit          m_mis   = 1'b0;
  int unsigned q_instr[$];
  int unsigned q_addr[$];

  always @(negedge clk) begin : monitor
    bit exp_rdy;
    bit hs;
    bit fin;
    if (rst) begin
      m_state = 0; m_acc = 0; m_cnt = 0; m_addr = BASE_ADDR; m_ill = 1'b0; m_mis = 1'b0;
      q_instr.delete();
      q_addr.delete();
    end
    exp_rdy = (m_state == 1) && (m_acc < DEPTH) && ((q_instr.size() == 0) || out_ready);
    chk("out_valid", 32'(out_valid), 32'(q_instr.size() != 0));
    if (q_instr.size() != 0) begin
      chk("out_instr", out_instr, q_instr[0]);
      chk("out_addr", 32'(out_addr), q_addr[0]);
    end
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("count", 32'(count), m_cnt);
    chk("busy", 32'(busy), 32'(m_state == 1));
    chk("done", 32'(done), 32'(m_state == 2));
    chk("err_illegal", 32'(err_illegal), 32'(m_ill));
    chk("err_misalign", 32'(err_misalign), 32'(m_mis));
    if (!rst) begin
      if (m_state != 1) begin
        if (start) begin
          m_state = 1; m_acc = 0; m_cnt = 0; m_addr = BASE_ADDR; m_ill = 1'b0; m_mis = 1'b0;
        end
      end else begin
        hs  = (q_instr.size() != 0) && out_ready;
        fin = (m_acc == DEPTH) && ((q_instr.size() == 0) || hs);
        if (hs) begin
          void'(q_instr.pop_front());
          void'(q_addr.pop_front());
          m_cnt++;
        end
        if (in_valid && exp_rdy) begin
          m_acc++;
          if (in_fmt > 3'd5) begin
            m_ill = 1'b1;
          end else begin
            q_instr.push_back(ref_word(32'(in_fmt), 32'(in_opcode), 32'(in_rd), 32'(in_rs1),
                                       32'(in_rs2), 32'(in_funct3), 32'(in_funct7), in_imm));
            q_addr.push_back(m_addr);
            m_addr = (m_addr + 1) % (1 << ADDR_W);
            if ((in_fmt == 3'd3 || in_fmt == 3'd5) && in_imm[0]) m_mis = 1'b1;
          end
        end
        if (fin) m_state = 2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_fields(input int fmt, input int op, input int rd, input int rs1,
                            input int rs2, input int f3, input int f7, input logic [31:0] imm);
    in_fmt    = 3'(fmt);
    in_opcode = 7'(op);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_funct3 = 3'(f3);
    in_funct7 = 7'(f7);
    in_imm    = imm;
  endtask

  // Presents one bundle and returns just after the edge that accepts it.
  task automatic send(input int fmt, input int op, input int rd, input int rs1,
                      input int rs2, input int f3, input int f7, input logic [31:0] imm);
    bit taken;
    taken = 1'b0;
    set_fields(fmt, op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !taken; i++) begin
      if (in_ready) taken = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("send_accepted", 32'(taken), 32'd1);
  endtask

  task automatic rand_run();
    for (int i = 0; i < 400 && !done; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      start     = ($urandom_range(0, 15) == 0);
      set_fields(int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 127)), $urandom);
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("run_done", 32'(done), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0000_0000);
    chk("rst_out_addr", 32'(out_addr), 32'd1020);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Directed encodings, out_ready held high.
    do_start();
    chk("start_busy", 32'(busy), 32'd1);
    send(0, 'h33, 1, 2, 3, 0, 0, 32'h0);
    chk("add_latency", 32'(out_valid), 32'd1);
    chk("add_word", out_instr, 32'h003100B3);
    chk("add_addr", 32'(out_addr), 32'd1020);
    send(1, 'h13, 5, 0, 0, 0, 0, 32'hFFFFFFFF);
    chk("addi_word", out_instr, 32'hFFF00293);
    chk("addi_addr", 32'(out_addr), 32'd1021);
    send(2, 'h23, 0, 1, 2, 2, 0, 32'd8);
    chk("sw_word", out_instr, 32'h0020A423);
    send(3, 'h63, 0, 0, 0, 0, 0, 32'hFFFFFFFC);
    chk("beq_word", out_instr, 32'hFE000EE3);
    chk("beq_addr", 32'(out_addr), 32'd1023);
    send(5, 'h6F, 1, 0, 0, 0, 0, 32'd8);
    chk("jal_word", out_instr, 32'h008000EF);
    chk("jal_addr_wrap", 32'(out_addr), 32'd0);
    send(4, 'h37, 10, 0, 0, 0, 0, 32'h12345000);
    chk("lui_word", out_instr, 32'h12345537);
    send(7, 'h33, 1, 1, 1, 0, 0, 32'h0);
    chk("illegal_flag", 32'(err_illegal), 32'd1);
    chk("illegal_no_word", 32'(out_valid), 32'd0);
    send(3, 'h63, 0, 0, 0, 0, 0, 32'd3);
    chk("misalign_word", out_instr, 32'h00000163);
    chk("misalign_addr", 32'(out_addr), 32'd2);
    chk("misalign_flag", 32'(err_misalign), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("end_done", 32'(done), 32'd1);
    chk("end_count", 32'(count), 32'd7);
    chk("end_in_ready", 32'(in_ready), 32'd0);
    do_start();
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_count", 32'(count), 32'd0);
    chk("restart_ill_clr", 32'(err_illegal), 32'd0);
    chk("restart_mis_clr", 32'(err_misalign), 32'd0);

    // Backpressure: one word held while the next bundle waits.
    out_ready = 1'b0;
    set_fields(0, 'h33, 1, 2, 3, 0, 0, 32'h0);
    in_valid = 1'b1;
    tick();
    set_fields(1, 'h13, 5, 0, 0, 0, 0, 32'hFFFFFFFF);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_word", out_instr, 32'h003100B3);
      chk("bp_addr", 32'(out_addr), 32'd1020);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_next_word", out_instr, 32'hFFF00293);
    chk("bp_next_addr", 32'(out_addr), 32'd1021);

    // Randomized runs: finish the current one, then several fresh ones.
    rand_run();
    for (int r = 0; r < 25; r++) begin
      do_start();
      rand_run();
    end

    // Reset mid-run with a word stalled in the output register.
    out_ready = 1'b1;
    do_start();
    out_ready = 1'b0;
    send(0, 'h33, 1, 2, 3, 0, 0, 32'h0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'(busy | done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
